uart_rx: RTL and testbench

- Receive end of the team's UART link.
- Deserialises LSB-first frames: start bit, DATA_WIDTH data bits, optional parity bit, one stop bit.
- Samples RX_IN with a per-bit oversampling counter; three-sample majority vote at bit centre.
- Presents P_DATA with a one-cycle data_valid pulse, and flags parity and stop (framing) errors. Parity convention matches the UART transmitter (PAR_TYP 0 = even, 1 = odd).

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_sampler.sv | 57 +++++
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receive path.
// Holds the FSM state encoding, the legal Prescale values, the parity-type
// encodings, a default data width and the majority-vote helper.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_PRESCALE_WIDTH = 6;

  // Receiver FSM encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Supported oversampling ratios (CLK cycles per bit)
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // PAR_TYP encodings
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit oversampling counter with a three-sample majority vote.
// Ports: clk_i/rst_i (async active-high), en_i (frame in progress), rx_i (line),
//        prescale_i (cycles per bit); vote_o (voted bit), bit_done_o (last cycle of bit).
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      rx_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      vote_o,
  output logic                      bit_done_o
);

  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]                smp_q, smp_d;
  logic [PRESCALE_WIDTH-1:0] half, smp_at0, smp_at1, smp_at2, last_cnt;

  // Compare points wrap modulo 2**PRESCALE_WIDTH, so an unsupported Prescale
  // still lets the counter reach last_cnt and the FSM keeps moving.
  assign half     = prescale_i >> 1;
  assign smp_at0  = half - PRESCALE_WIDTH'(1);
  assign smp_at1  = half;
  assign smp_at2  = half + PRESCALE_WIDTH'(1);
  assign last_cnt = prescale_i - PRESCALE_WIDTH'(1);

  assign bit_done_o = en_i && (edge_cnt_q == last_cnt);
  assign vote_o     = majority3(smp_q[0], smp_q[1], smp_q[2]);

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    smp_d      = smp_q;
    // Held at 0 while idle so the first START cycle always sees edge_cnt = 0.
    if (!en_i || bit_done_o) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);
    end
    if (edge_cnt_q == smp_at0) smp_d[0] = rx_i;
    if (edge_cnt_q == smp_at1) smp_d[1] = rx_i;
    if (edge_cnt_q == smp_at2) smp_d[2] = rx_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      edge_cnt_q <= '0;
      smp_q      <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      smp_q      <= smp_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, LSB-first, start + DATA_WIDTH data + optional parity + 1 stop.
// Ports: CLK, RST (async active-high), RX_IN, Prescale, PAR_EN, PAR_TYP in;
//        P_DATA, data_valid, par_err, stp_err out. Macro UART_RX_SYNC_EN adds a 2-flop RX_IN synchroniser.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  logic rx;

`ifdef UART_RX_SYNC_EN
  logic sync1_q, sync2_q;

  // Reset to the idle level so leaving reset never looks like a start bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      sync2_q <= sync1_q;
    end
  end
  assign rx = sync2_q;
`else
  assign rx = RX_IN;
`endif

  logic [2:0]                state_q, state_d;
  logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic                      par_fail_q, par_fail_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
  logic                      data_valid_q, data_valid_d;
  logic                      par_err_q, par_err_d;
  logic                      stp_err_q, stp_err_d;
  logic                      vote, bit_done, take_start, par_exp;

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .clk_i      (CLK),
    .rst_i      (RST),
    .en_i       (state_q != ST_IDLE),
    .rx_i       (rx),
    .prescale_i (prescale_q),
    .vote_o     (vote),
    .bit_done_o (bit_done)
  );

  assign par_exp = (^shift_q) ^ (par_typ_q == PAR_ODD);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_fail_d   = par_fail_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    take_start   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        take_start = !rx;
      end
      ST_START: begin
        // A start bit that votes high was a glitch: drop it silently.
        if (bit_done) state_d = vote ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          par_fail_d = (vote != par_exp);
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_d      = ST_IDLE;
          stp_err_d    = !vote;
          par_err_d    = par_fail_q;
          data_valid_d = vote && !par_fail_q;
          if (vote && !par_fail_q) p_data_d = shift_q;
          // The line cycle after the stop bit is the first cycle a gapless
          // sender can drive its next start bit; catch it here so
          // back-to-back frames keep their exact spacing.
          take_start = !rx;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_start) begin
      state_d    = ST_START;
      bit_cnt_d  = '0;
      par_fail_d = 1'b0;
      prescale_d = Prescale;
      par_en_d   = PAR_EN;
      par_typ_d  = PAR_TYP;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_fail_q   <= 1'b0;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_fail_q   <= par_fail_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx with a queue-based scoreboard.
// Stimulus pushes the expected pulse (flags, P_DATA, cycle); a negedge monitor
// pops and compares whenever any output pulse appears.
module tb_uart_rx;
  import uart_pkg::*;

`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx #(
    .DATA_WIDTH    (8),
    .PRESCALE_WIDTH(6)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .Prescale  (Prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err)
  );

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] model_pdata = 8'h00;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: any output pulse must match the oldest pending expectation.
  always @(negedge CLK) begin
    if (!RST && (data_valid || par_err || stp_err)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse actual dv=%0b pe=%0b se=%0b data=%h required none",
                 data_valid, par_err, stp_err, P_DATA);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("flags{dv,pe,se}", {29'd0, data_valid, par_err, stp_err}, {29'd0, e.dv, e.pe, e.se});
        check("p_data", {24'd0, P_DATA}, {24'd0, e.data});
        if (e.cyc >= 0) check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic line_n(input logic v, input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      RX_IN = v;
    end
  endtask

  // Drives one frame with the current Prescale/PAR_EN. glitch_bit is the frame
  // bit index (0 = start) that gets a one-cycle inversion at its centre sample.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                            input int glitch_bit, input logic edv, input logic epe,
                            input logic ese, input logic chk_lat);
    int          p;
    int          nb;
    int          c;
    logic [10:0] bits;
    exp_t        e;
    p         = int'(Prescale);
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    nb        = 9;
    if (PAR_EN) begin
      bits[nb] = pbit;
      nb++;
    end
    bits[nb] = sbit;
    nb++;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < p; k++) begin
        @(posedge CLK);
        #1;
        if (b == 0 && k == 0) begin
          c      = cyc;
          e.dv   = edv;
          e.pe   = epe;
          e.se   = ese;
          e.data = edv ? d : model_pdata;
          e.cyc  = chk_lat ? (c + 1 + nb * p + SYNC_LAT) : -1;
          if (edv) model_pdata = d;
          exp_q.push_back(e);
        end
        RX_IN = (b == glitch_bit && k == p / 2 + 1) ? ~bits[b] : bits[b];
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge CLK);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] d81;
    d81      = 8'h81;
    RST      = 1'b1;
    RX_IN    = 1'b1;
    Prescale = 6'(PRESCALE_8);
    PAR_EN   = 1'b1;
    PAR_TYP  = PAR_EVEN;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_p_data", {24'd0, P_DATA}, 32'h0);
    check("reset_data_valid", {31'd0, data_valid}, 32'h0);
    check("reset_par_err", {31'd0, par_err}, 32'h0);
    check("reset_stp_err", {31'd0, stp_err}, 32'h0);
    RST = 1'b0;
    line_n(1'b1, 5);

    // Prescale 8, even parity, 0xA5 (four ones -> parity 0): 88-cycle latency
    send_frame(8'hA5, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 1'b1);
    line_n(1'b1, 6);
    drain("drain_a5");

    // Prescale 16, odd parity, 0x3C needs parity 1 but 0 is sent
    Prescale = 6'(PRESCALE_16);
    PAR_TYP  = PAR_ODD;
    send_frame(8'h3C, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b1);
    line_n(1'b1, 6);
    drain("drain_par_err");

    // Prescale 32, no parity: stop bit low, then a clean 0x12
    Prescale = 6'(PRESCALE_32);
    PAR_EN   = 1'b0;
    send_frame(8'hFF, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    line_n(1'b1, 6);
    drain("drain_stp_err");
    send_frame(8'h12, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 1'b1);
    line_n(1'b1, 6);
    drain("drain_12");

    // Prescale 16: 3-cycle low pulse is rejected; then a glitch in data bit 2
    Prescale = 6'(PRESCALE_16);
    line_n(1'b0, 3);
    line_n(1'b1, 40);
    check("glitch_start_quiet", exp_q.size(), 0);
    send_frame(8'h00, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    line_n(1'b1, 6);
    drain("drain_00");

    // Prescale 8, even parity: 0x55 then 0xAA with no idle gap
    Prescale = 6'(PRESCALE_8);
    PAR_EN   = 1'b1;
    PAR_TYP  = PAR_EVEN;
    send_frame(8'h55, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 1'b1);
    line_n(1'b1, 6);
    drain("drain_b2b");

    // Reset in the middle of data bit 4 of 0x81, then a full 0x81
    PAR_EN = 1'b0;
    line_n(1'b0, 8);
    for (int b = 0; b < 4; b++) line_n(d81[b], 8);
    line_n(d81[4], 4);
    #2;
    RST = 1'b1;
    #1;
    model_pdata = 8'h00;
    check("rst_mid_p_data", {24'd0, P_DATA}, 32'h0);
    check("rst_mid_data_valid", {31'd0, data_valid}, 32'h0);
    check("rst_mid_par_err", {31'd0, par_err}, 32'h0);
    check("rst_mid_stp_err", {31'd0, stp_err}, 32'h0);
    RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    line_n(1'b1, 5);
    send_frame(8'h81, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 1'b1);
    line_n(1'b1, 6);
    drain("drain_81");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
